load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory interface. Accepts load/store requests from the CPU datapath through a valid/ready handshake and converts byte addresses and byte/halfword/word sizes into word-indexed strobes on the data memory. It drives `mem_read`, `mem_write`, `mem_address` and `mem_write_data`, and captures `mem_read_data`. It also performs sign/zero extension on loads and read-modify-write merging on sub-word stores.

## Interface

Parameters:
- `ADDR_WORDS`, 256, number of 32-bit words in the attached data memory; word indices ≥ `ADDR_WORDS` are out of range.

Ports:
- `clk`  input  1  clock. Everything is rising-edge triggered.
- `reset`  input  1  asynchronous, active-high reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  unit can accept a request.
- `req_write`  input  1  1 = store, 0 = load.
- `req_size`  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_signed`  input  1  sign-extend load result. Ignored for stores and word loads.
- `req_addr`  input  32  byte address.
- `req_wdata`  input  32  store data, right-aligned: the byte is in [7:0], the halfword in [15:0].
- `resp_valid`  output  1  one-cycle completion pulse.
- `resp_rdata`  output  32  extended load data. 0 for stores and errors.
- `resp_error`  output  1  misaligned access, illegal size, or out-of-range address. Qualified by `resp_valid`.
- `mem_address`  output  32  word index, equal to `req_addr[31:2]` zero-extended.
- `mem_write_data`  output  32  full word to write.
- `mem_read`  output  1  read strobe.
- `mem_write`  output  1  write strobe.
- `mem_read_data`  input  32  combinational read data from memory.

## Operation

- FSM states: IDLE, READ, WRITE, RESP.
- `req_ready` = (state == IDLE) && !`reset`. A request is accepted when `req_valid` && `req_ready`. All request fields are latched on acceptance.
- Validation at acceptance. Set the error condition if any of these hold:
  - `req_size` == 11
  - halfword with `addr[0]` ≠ 0
  - word with `addr[1:0]` ≠ 0
  - `req_addr[31:2]` ≥ `ADDR_WORDS`
- Error request: IDLE→RESP with `resp_error`=1. No memory strobe is ever asserted.
- Load: IDLE→READ→RESP.
  - In READ: `mem_read`=1 and `mem_address` = word index. `mem_read_data` is captured at the end of READ.
  - Lane select is little-endian: byte offset k maps to bits [8k+7:8k]; a halfword at offset 2 maps to [31:16].
  - The selected lane is sign-extended if `req_signed`, otherwise zero-extended.
- Word store: IDLE→WRITE→RESP. In WRITE: `mem_write`=1 and `mem_write_data` = `req_wdata`.
- Sub-word store: IDLE→READ→WRITE→RESP.
  - READ fetches the old word.
  - WRITE drives the old word with the addressed lane(s) replaced by `req_wdata`[7:0] or [15:0]. All other bytes are preserved.
- RESP: `resp_valid`=1 for exactly one cycle, then →IDLE. There is no response backpressure.
- `mem_read` and `mem_write` are never asserted in the same cycle. Each strobe lasts exactly one cycle per access.
- Reset:
  - state = IDLE.
  - `resp_valid`, `resp_error`, `mem_read`, `mem_write` = 0.
  - `resp_rdata`, `mem_address`, `mem_write_data` = 0.
  - All outputs are registered except `req_ready`.
- Reset mid-operation: the in-flight request is dropped with no response. Strobes fall asynchronously with `reset`. For a sub-word store, a write not yet issued is never issued.

## Timing

Cycle 0 is the acceptance edge.
- Word load: `mem_read` high in cycle 1; `resp_valid` in cycle 2.
- Word store: `mem_write` high in cycle 1; `resp_valid` in cycle 2.
- Sub-word load: same timing as a word load.
- Sub-word store: `mem_read` in cycle 1, `mem_write` in cycle 2, `resp_valid` in cycle 3.
- Error: `resp_valid` in cycle 1.
- `req_ready` is low from cycle 1 through the RESP cycle and high again the cycle after RESP. Back-to-back throughput is therefore one request per 3 cycles for word accesses.
- `mem_address` and `mem_write_data` are stable for the entire cycle in which their strobe is high.

## Test plan

Memory word 4 is preloaded with 0x8899AABB for all scenarios.
- Word load, `addr`=0x10 → cycle 1: `mem_read`=1, `mem_address`=4. Cycle 2: `resp_valid`=1, `resp_rdata`=0x8899AABB, `resp_error`=0.
- Byte load, `addr`=0x13:
  - signed → `resp_rdata`=0xFFFFFF88.
  - unsigned → `resp_rdata`=0x00000088.
  - Halfword signed load at 0x10 → 0xFFFFAABB.
- Byte store, `addr`=0x11, `wdata`=0x00000055 → cycle 1 read of word 4. Cycle 2: `mem_write`=1, `mem_write_data`=0x889955BB. Cycle 3: `resp_valid`. A subsequent word load returns 0x889955BB.
- Error requests, each giving a cycle-1 `resp_valid` with `resp_error`=1, `mem_read`=`mem_write`=0 throughout, and `resp_rdata`=0:
  - halfword store at 0x11
  - word load at 0x400 (word 256)
  - `req_size`=11
- Reset asserted during cycle 1 of a byte store to 0x12 → `mem_read` falls immediately. No `mem_write` and no `resp_valid` ever occur. Word 4 is unchanged. `req_ready`=1 after reset deasserts.
- `req_valid` held high with 3 queued word loads → acceptances exactly 3 cycles apart. `req_ready` is never high outside IDLE. Each response appears 2 cycles after its acceptance.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus between the CPU datapath,
// the load/store unit and the attached data memory.
interface load_store_unit_if;
    // CPU request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // CPU response channel
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    // data-memory bus
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    // View taken by the load/store unit
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write_data, mem_read, mem_write
    );

    // View taken by the surrounding CPU datapath and memory
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed load/store requests into word-indexed
// memory strobes, extends sub-word loads and merges sub-word stores by
// read-modify-write. All outputs except req_ready are registered.
module load_store_unit #(
    parameter int ADDR_WORDS = 256
) (
    input  logic            clk,
    input  logic            reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [30:0] WORD_LIMIT = 31'(ADDR_WORDS);

    state_t      state_q, state_d;
    logic        accept;
    logic        req_err;

    // Request fields held for the lifetime of the access
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    // Registered outputs
    logic        mem_read_q,       mem_read_d;
    logic        mem_write_q,      mem_write_d;
    logic [31:0] mem_address_q,    mem_address_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic        resp_valid_q,     resp_valid_d;
    logic        resp_error_q,     resp_error_d;
    logic [31:0] resp_rdata_q,     resp_rdata_d;

    // Illegal size, misalignment or a word index past the end of memory
    function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = 1'b0;
        case (size)
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
        if ({1'b0, addr[31:2]} >= WORD_LIMIT) bad = 1'b1;
        return bad;
    endfunction

    // Little-endian lane select followed by sign or zero extension
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of the old word with the store data
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] m;
        m = old;
        case (size)
            2'b00: m[{off, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (off[1]) m[31:16] = wd[15:0];
                else        m[15:0]  = wd[15:0];
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_err       = access_error(bus.req_size, bus.req_addr);

    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_error     = resp_error_q;
    assign bus.resp_rdata     = resp_rdata_q;

    // State and output registers; reset drops any in-flight access at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            resp_valid_q     <= 1'b0;
            resp_error_q     <= 1'b0;
            resp_rdata_q     <= '0;
        end else begin
            state_q          <= state_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            resp_valid_q     <= resp_valid_d;
            resp_error_q     <= resp_error_d;
            resp_rdata_q     <= resp_rdata_d;
        end
    end

    // Latch request fields on acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q  <= bus.req_write;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            off_q    <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata;
        end
    end

    // Next state: errors skip memory, word stores skip the read, sub-word stores read first
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                                     state_d = RESP;
                    else if (bus.req_write && bus.req_size == 2'b10) state_d = WRITE;
                    else                                             state_d = READ;
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values, registered alongside the state
    always_comb begin
        mem_read_d       = (state_d == READ);
        mem_write_d      = (state_d == WRITE);
        resp_valid_d     = (state_d == RESP);
        resp_error_d     = accept && req_err;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        resp_rdata_d     = '0;
        if (accept) begin
            mem_address_d = {2'b00, bus.req_addr[31:2]};
            if (!req_err && bus.req_write && bus.req_size == 2'b10)
                mem_write_data_d = bus.req_wdata;
        end
        if (state_q == READ) begin
            if (write_q) mem_write_data_d = store_merge(bus.mem_read_data, wdata_q, size_q, off_q);
            else         resp_rdata_d     = load_extend(bus.mem_read_data, size_q, off_q, signed_q);
        end
    end
endmodule
